// File: rtl/sliding_window_stream.sv
// ---------------------------------------------------------------------------
// sliding_window_stream
//   Turns a row-major pixel stream into WINDOW x WINDOW valid-only windows,
//   stepping STRIDE pixels in rows and columns.  Uses WINDOW-1 line buffers
//   and a WINDOW x WINDOW shift array.  The window output is a single
//   registered slot with combinational backpressure.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input pixel present
//   in_ready   : pixel accepted this cycle (= !win_valid || win_ready)
//   in_data    : pixel, channel ch at [ch*PIXEL_WIDTH +: PIXEL_WIDTH]
//   in_sof     : start of frame; this pixel is treated as (0,0)
//   win_valid  : window present
//   win_ready  : downstream accepts the window
//   win_data   : sample (r,c,ch) at [((r*WINDOW+c)*CHANNELS+ch)*PIXEL_WIDTH +: PIXEL_WIDTH]
//   win_last   : final window of the frame
// ---------------------------------------------------------------------------
module sliding_window_stream #(
   parameter int WIDTH       = 64,
   parameter int HEIGHT      = 64,
   parameter int PIXEL_WIDTH = 8,
   parameter int CHANNELS    = 1,
   parameter int WINDOW      = 3,
   parameter int STRIDE      = 1
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [CHANNELS*PIXEL_WIDTH-1:0]               in_data,
   input  logic                                          in_sof,
   output logic                                          win_valid,
   input  logic                                          win_ready,
   output logic [WINDOW*WINDOW*CHANNELS*PIXEL_WIDTH-1:0] win_data,
   output logic                                          win_last
);

   localparam int PW     = CHANNELS * PIXEL_WIDTH;
   localparam int WW     = WINDOW * WINDOW * PW;
   localparam int CW     = $clog2(WIDTH);
   localparam int RW     = $clog2(HEIGHT);
   localparam int SW     = $clog2(STRIDE + 1);
   localparam int LAST_R = WINDOW - 1 + STRIDE * ((HEIGHT - WINDOW) / STRIDE);
   localparam int LAST_C = WINDOW - 1 + STRIDE * ((WIDTH - WINDOW) / STRIDE);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   // Stride phase of the next pixel; held at 0 until the first window
   // position so that "(pos-WINDOW+1) mod STRIDE == 0" needs no divider.
   logic [SW-1:0] r_cph;
   logic [SW-1:0] r_rph;
   logic          r_valid;
   logic          r_last;
   logic [WW-1:0] r_win_data;

   logic [PW-1:0] r_lb  [WINDOW-1][WIDTH];
   logic [PW-1:0] r_win [WINDOW][WINDOW];

   logic          w_xfer;
   logic          w_emit;
   logic          w_last;
   logic          w_eol;
   logic          w_eof;
   logic [CW-1:0] w_c;
   logic [RW-1:0] w_r;
   logic [SW-1:0] w_cp;
   logic [SW-1:0] w_rp;
   logic [SW-1:0] w_cp_nxt;
   logic [SW-1:0] w_rp_nxt;
   logic [PW-1:0] w_colv [WINDOW];
   logic [PW-1:0] w_next [WINDOW][WINDOW];
   logic [WW-1:0] w_flat;

   assign in_ready  = !r_valid || win_ready;
   assign win_valid = r_valid;
   assign win_last  = r_last;
   assign win_data  = r_win_data;

   always_comb begin
      w_xfer = in_valid && in_ready;
      // in_sof overrides whatever position the counters hold
      w_c    = in_sof ? '0 : r_col;
      w_r    = in_sof ? '0 : r_row;
      w_cp   = in_sof ? '0 : r_cph;
      w_rp   = in_sof ? '0 : r_rph;
      w_eol  = (w_c == CW'(WIDTH - 1));
      w_eof  = w_eol && (w_r == RW'(HEIGHT - 1));
      w_emit = w_xfer && (w_r >= RW'(WINDOW - 1)) && (w_c >= CW'(WINDOW - 1)) &&
               (w_rp == '0) && (w_cp == '0);
      w_last = (w_r == RW'(LAST_R)) && (w_c == CW'(LAST_C));

      w_cp_nxt = (w_c < CW'(WINDOW - 1) || w_cp == SW'(STRIDE - 1) || w_eol) ?
                 '0 : w_cp + 1'b1;
      w_rp_nxt = (w_r < RW'(WINDOW - 1) || w_rp == SW'(STRIDE - 1) || w_eof) ?
                 '0 : w_rp + 1'b1;

      // New column: current pixel at the bottom, older rows from line buffers
      w_colv[WINDOW-1] = in_data;
      for (int unsigned k = 0; k < WINDOW - 1; k++)
         w_colv[WINDOW-2-k] = r_lb[k][w_c];

      for (int unsigned r = 0; r < WINDOW; r++)
         for (int unsigned c = 0; c < WINDOW; c++)
            w_next[r][c] = (c < WINDOW - 1) ? r_win[r][c+1] : w_colv[r];

      w_flat = '0;
      for (int unsigned r = 0; r < WINDOW; r++)
         for (int unsigned c = 0; c < WINDOW; c++)
            w_flat[(r*WINDOW+c)*PW +: PW] = w_next[r][c];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_cph      <= '0;
         r_rph      <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_win_data <= '0;
      end else begin
         if (w_xfer) begin
            r_col <= w_eol ? '0 : w_c + 1'b1;
            r_cph <= w_cp_nxt;
            if (w_eol) begin
               r_row <= w_eof ? '0 : w_r + 1'b1;
               r_rph <= w_rp_nxt;
            end else begin
               r_row <= w_r;
               r_rph <= w_rp;
            end
         end
         if (w_emit) begin
            r_valid    <= 1'b1;
            r_last     <= w_last;
            r_win_data <= w_flat;
         end else if (win_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   // Pixel storage: no reset, written only on an input transfer.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_lb[0][w_c] <= in_data;
         for (int unsigned k = 1; k < WINDOW - 1; k++)
            r_lb[k][w_c] <= r_lb[k-1][w_c];
         for (int unsigned r = 0; r < WINDOW; r++)
            for (int unsigned c = 0; c < WINDOW; c++)
               r_win[r][c] <= w_next[r][c];
      end
   end

endmodule

// File: tb/tb_sliding_window_stream.sv
module tb_sliding_window_stream;

   typedef struct {
      logic [215:0] d;
      logic         l;
   } exp_t;

   typedef struct {
      int dut;
      int idx;
      int s00;
      int s11;
      int s22;
      int last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_sof;
   logic [7:0]  in_data1;
   logic [23:0] in_data3;
   logic        wr0;

   logic        ir1, ir2, ir3;
   logic        wv1, wv2, wv3;
   logic        wl1, wl2, wl3;
   logic [71:0] wd1, wd2;
   logic [215:0] wd3;
   logic        gated_valid;

   logic         ir [3];
   logic         wv [3];
   logic         wrd[3];
   logic         wl [3];
   logic [215:0] wd [3];

   int checks   = 0;
   int failures = 0;

   exp_t sbq [3][$];
   exp_t cap [3][$];
   vec_t vt  [10];

   int   img [6][8];
   int   mr, mc, pr_r, pr_c;
   logic pushed [3];
   logic pv [3];
   logic pr [3];
   logic [215:0] pd [3];
   logic pl [3];
   logic ev;
   exp_t e;

   always #5 clk = ~clk;

   assign gated_valid = in_valid && ir1;

   sliding_window_stream #(.WIDTH(8), .HEIGHT(6), .PIXEL_WIDTH(8), .CHANNELS(1),
                           .WINDOW(3), .STRIDE(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data1),
      .in_sof(in_sof), .win_valid(wv1), .win_ready(wr0), .win_data(wd1), .win_last(wl1));

   sliding_window_stream #(.WIDTH(8), .HEIGHT(6), .PIXEL_WIDTH(8), .CHANNELS(1),
                           .WINDOW(3), .STRIDE(2)) u_s2 (
      .clk(clk), .rst(rst), .in_valid(gated_valid), .in_ready(ir2), .in_data(in_data1),
      .in_sof(in_sof), .win_valid(wv2), .win_ready(1'b1), .win_data(wd2), .win_last(wl2));

   sliding_window_stream #(.WIDTH(8), .HEIGHT(6), .PIXEL_WIDTH(8), .CHANNELS(3),
                           .WINDOW(3), .STRIDE(1)) u_c3 (
      .clk(clk), .rst(rst), .in_valid(gated_valid), .in_ready(ir3), .in_data(in_data3),
      .in_sof(in_sof), .win_valid(wv3), .win_ready(1'b1), .win_data(wd3), .win_last(wl3));

   assign ir[0] = ir1;  assign ir[1] = ir2;  assign ir[2] = ir3;
   assign wv[0] = wv1;  assign wv[1] = wv2;  assign wv[2] = wv3;
   assign wl[0] = wl1;  assign wl[1] = wl2;  assign wl[2] = wl3;
   assign wrd[0] = wr0; assign wrd[1] = 1'b1; assign wrd[2] = 1'b1;
   assign wd[0] = 216'(wd1);
   assign wd[1] = 216'(wd2);
   assign wd[2] = wd3;

   task automatic check(input string name, input logic [215:0] act, input logic [215:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int stride_of(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic int chans_of(input int k);
      return (k == 2) ? 3 : 1;
   endfunction

   function automatic logic [7:0] samp(input logic [215:0] d, input int r, input int c,
                                       input int chs, input int h);
      return d[((r*3+c)*chs+h)*8 +: 8];
   endfunction

   // Expected window built straight from the frame image the bench sent
   function automatic logic [215:0] mkwin(input int R, input int C, input int chs);
      logic [215:0] w;
      logic [7:0]   v;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            for (int h = 0; h < chs; h++) begin
               v = 8'(img[R-2+r][C-2+c] + 64*h);
               w[((r*3+c)*chs+h)*8 +: 8] = v;
            end
      return w;
   endfunction

   // Scoreboard / protocol monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         mr = 0;
         mc = 0;
         for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            pushed[k] = 1'b0;
            pv[k] = 1'b0;
            pr[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            ev = pushed[k] || (pv[k] && !pr[k]);
            check($sformatf("d%0d_valid", k), 216'(wv[k]), 216'(ev));
            check($sformatf("d%0d_in_ready", k), 216'(ir[k]), 216'(!wv[k] || wrd[k]));
            if (pv[k] && !pr[k] && !pushed[k]) begin
               check($sformatf("d%0d_hold_data", k), wd[k], pd[k]);
               check($sformatf("d%0d_hold_last", k), 216'(wl[k]), 216'(pl[k]));
            end
            if (wv[k] && wrd[k]) begin
               if (sbq[k].size() == 0) begin
                  check($sformatf("d%0d_extra_window", k), 216'(1), 216'(0));
               end else begin
                  e = sbq[k].pop_front();
                  check($sformatf("d%0d_win_data", k), wd[k], e.d);
                  check($sformatf("d%0d_win_last", k), 216'(wl[k]), 216'(e.l));
               end
               e.d = wd[k];
               e.l = wl[k];
               cap[k].push_back(e);
            end
            pv[k] = wv[k];
            pr[k] = wrd[k];
            pd[k] = wd[k];
            pl[k] = wl[k];
         end
         if (in_valid && ir1) begin
            pr_r = in_sof ? 0 : mr;
            pr_c = in_sof ? 0 : mc;
            img[pr_r][pr_c] = int'(in_data1);
            for (int k = 0; k < 3; k++) begin
               pushed[k] = 1'b0;
               if (pr_r >= 2 && pr_c >= 2 && ((pr_r-2) % stride_of(k)) == 0 &&
                   ((pr_c-2) % stride_of(k)) == 0) begin
                  e.d = mkwin(pr_r, pr_c, chans_of(k));
                  e.l = (pr_r == 2 + stride_of(k)*(3/stride_of(k))) &&
                        (pr_c == 2 + stride_of(k)*(5/stride_of(k)));
                  sbq[k].push_back(e);
                  pushed[k] = 1'b1;
               end
            end
            mc = pr_c + 1;
            mr = pr_r;
            if (mc == 8) begin
               mc = 0;
               mr = (pr_r == 5) ? 0 : pr_r + 1;
            end
         end else begin
            for (int k = 0; k < 3; k++) pushed[k] = 1'b0;
         end
      end
   end

   task automatic send(input int R, input int C, input bit sof, input int off);
      bit took;
      in_valid = 1'b1;
      in_sof   = sof;
      in_data1 = 8'(R*8 + C + off);
      in_data3 = {8'(R*8 + C + off + 128), 8'(R*8 + C + off + 64), 8'(R*8 + C + off)};
      took = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ir1) begin
            took = 1'b1;
            break;
         end
      end
      if (!took) check("send_timeout", 216'(0), 216'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input bit sof, input int off);
      for (int R = 0; R < 6; R++)
         for (int C = 0; C < 8; C++)
            send(R, C, sof && R == 0 && C == 0, off);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      for (int k = 0; k < 3; k++) cap[k].delete();
   endtask

   task automatic run_table(input int only_dut);
      for (int i = 0; i < 10; i++) begin
         if (only_dut < 0 || vt[i].dut == only_dut) begin
            if (cap[vt[i].dut].size() <= vt[i].idx) begin
               check($sformatf("tbl%0d_missing", i), 216'(cap[vt[i].dut].size()),
                     216'(vt[i].idx + 1));
            end else begin
               e = cap[vt[i].dut][vt[i].idx];
               check($sformatf("tbl%0d_s00", i), 216'(samp(e.d, 0, 0, 1, 0)), 216'(vt[i].s00));
               check($sformatf("tbl%0d_s11", i), 216'(samp(e.d, 1, 1, 1, 0)), 216'(vt[i].s11));
               check($sformatf("tbl%0d_s22", i), 216'(samp(e.d, 2, 2, 1, 0)), 216'(vt[i].s22));
               check($sformatf("tbl%0d_last", i), 216'(e.l), 216'(vt[i].last));
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_d%0d_valid", tag, k), 216'(wv[k]), 216'(0));
         check($sformatf("%s_d%0d_last", tag, k), 216'(wl[k]), 216'(0));
         check($sformatf("%s_d%0d_data", tag, k), wd[k], 216'(0));
      end
   endtask

   initial begin
      vt[0] = '{0, 0,  0,  9, 18, 0};
      vt[1] = '{0, 1,  1, 10, 19, 0};
      vt[2] = '{0, 6,  8, 17, 26, 0};
      vt[3] = '{0, 23, 29, 38, 47, 1};
      vt[4] = '{1, 0,  0,  9, 18, 0};
      vt[5] = '{1, 1,  2, 11, 20, 0};
      vt[6] = '{1, 2,  4, 13, 22, 0};
      vt[7] = '{1, 3, 16, 25, 34, 0};
      vt[8] = '{1, 4, 18, 27, 36, 0};
      vt[9] = '{1, 5, 20, 29, 38, 1};

      rst = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_data1 = '0;
      in_data3 = '0;
      wr0 = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Continuous stream, STRIDE 1/2 and 3 channels in parallel
      clear_caps();
      send_frame(1'b1, 0);
      idle(4);
      run_table(-1);
      check("s1_count", 216'(cap[0].size()), 216'(24));
      check("s2_count", 216'(cap[1].size()), 216'(6));
      if (cap[2].size() > 0) begin
         check("c3_ch0", 216'(samp(cap[2][0].d, 2, 2, 3, 0)), 216'(18));
         check("c3_ch1", 216'(samp(cap[2][0].d, 2, 2, 3, 1)), 216'(82));
         check("c3_ch2", 216'(samp(cap[2][0].d, 2, 2, 3, 2)), 216'(146));
      end else begin
         check("c3_missing", 216'(0), 216'(1));
      end

      // Second frame without in_sof relies on counter wrap
      clear_caps();
      send_frame(1'b0, 0);
      idle(4);
      run_table(0);
      check("wrap_count", 216'(cap[0].size()), 216'(24));

      // Backpressure: hold win_ready low for 10 cycles from the first window
      clear_caps();
      wr0 = 1'b0;
      fork
         send_frame(1'b1, 0);
         begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 100; t++) begin
               @(negedge clk);
               if (wv1) begin
                  seen = 1'b1;
                  break;
               end
            end
            if (!seen) check("stall_no_window", 216'(0), 216'(1));
            for (int t = 0; t < 10; t++) begin
               if (t > 0) @(negedge clk);
               check("stall_in_ready", 216'(ir1), 216'(0));
               check("stall_s00", 216'(samp(wd[0], 0, 0, 1, 0)), 216'(0));
               check("stall_s11", 216'(samp(wd[0], 1, 1, 1, 0)), 216'(9));
               check("stall_s22", 216'(samp(wd[0], 2, 2, 1, 0)), 216'(18));
            end
            @(posedge clk);
            #1;
            wr0 = 1'b1;
         end
      join
      idle(4);
      run_table(0);
      check("stall_count", 216'(cap[0].size()), 216'(24));

      // in_sof reasserted at pixel (3,4): frame 2 (offset 100) restarts at (0,0)
      clear_caps();
      for (int R = 0; R < 4; R++)
         for (int C = 0; C < 8; C++)
            if (R < 3 || C < 4) send(R, C, R == 0 && C == 0, 0);
      send_frame(1'b1, 100);
      idle(4);
      check("sof_count", 216'(cap[0].size()), 216'(32));
      if (cap[0].size() > 8) begin
         check("sof_first_s00", 216'(samp(cap[0][8].d, 0, 0, 1, 0)), 216'(100));
         check("sof_first_s22", 216'(samp(cap[0][8].d, 2, 2, 1, 0)), 216'(118));
      end

      // Reset pulse after pixel (4,0), then a fresh frame without in_sof
      clear_caps();
      for (int R = 0; R < 5; R++)
         for (int C = 0; C < 8; C++)
            if (R < 4 || C == 0) send(R, C, R == 0 && C == 0, 0);
      idle(1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_caps();
      send_frame(1'b0, 0);
      idle(4);
      run_table(0);
      check("rst_count", 216'(cap[0].size()), 216'(24));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sliding_window_stream.md
SLIDING_WINDOW_STREAM -- requirements
Module: sliding_window_stream

Interface
REQ-001 Parameter WIDTH, default 64: pixels per row, at least WINDOW.
REQ-002 Parameter HEIGHT, default 64: rows per frame, at least WINDOW.
REQ-003 Parameter PIXEL_WIDTH, default 8: bits per channel sample.
REQ-004 Parameter CHANNELS, default 1: channels per pixel, at least 1.
REQ-005 Parameter WINDOW, default 3: window edge length, at least 2.
REQ-006 Parameter STRIDE, default 1: window step in rows and columns, at least 1.
REQ-007 clk  input  1: clock; all state updates on the rising edge.
REQ-008 rst  input  1: reset, asynchronous, active-high.
REQ-009 in_valid  input  1: input pixel present.
REQ-010 in_ready  output  1: block accepts the input pixel this cycle.
REQ-011 in_data  input  CHANNELS*PIXEL_WIDTH: pixel; channel ch occupies bits [ch*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-012 in_sof  input  1: start of frame; qualified by the input handshake.
REQ-013 win_valid  output  1: window present.
REQ-014 win_ready  input  1: downstream accepts the window.
REQ-015 win_data  output  WINDOW*WINDOW*CHANNELS*PIXEL_WIDTH: window; sample (r,c,ch) occupies bits [((r*WINDOW+c)*CHANNELS+ch)*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-016 win_last  output  1: this window is the final window of the frame.

Function
REQ-017 Input transfer: in_valid && in_ready; output transfer: win_valid && win_ready.
REQ-018 in_ready SHALL equal !win_valid || win_ready. This is combinational and provides single-register backpressure.
REQ-019 Input pixels arrive row-major; a column counter (0..WIDTH-1) and a row counter (0..HEIGHT-1) SHALL advance on each input transfer.
REQ-020 After the pixel at (HEIGHT-1, WIDTH-1), both counters SHALL wrap to (0,0).
REQ-021 An input transfer with in_sof=1 SHALL be treated as pixel (0,0); the next pixel is (0,1), regardless of the prior counter state.
REQ-022 Storage: WINDOW-1 line buffers of WIDTH pixels each, plus a WINDOW x WINDOW register array, all CHANNELS wide.
REQ-023 No storage SHALL change except on an input transfer.
REQ-024 Window geometry: r=0 is the oldest row and r=WINDOW-1 is the current row; c=0 is the leftmost column and c=WINDOW-1 is the just-accepted pixel.
REQ-025 A window SHALL be emitted when the accepted pixel (R,C) satisfies all of:
- R>=WINDOW-1
- C>=WINDOW-1
- (R-WINDOW+1) mod STRIDE = 0
- (C-WINDOW+1) mod STRIDE = 0
REQ-026 Windows are valid-only: no padding is applied and no window straddles a row or frame boundary.
REQ-027 Latency: win_valid and win_data SHALL be registered and assert on the cycle after the qualifying input transfer.
REQ-028 win_valid SHALL deassert after an output transfer unless a new window is loaded in the same cycle.
REQ-029 While win_valid=1 && win_ready=0, win_data and win_last SHALL hold stable.
REQ-030 win_last SHALL be 1 for the window at R=WINDOW-1+STRIDE*floor((HEIGHT-WINDOW)/STRIDE) and C=WINDOW-1+STRIDE*floor((WIDTH-WINDOW)/STRIDE). It SHALL be 0 otherwise.
REQ-031 Windows per frame SHALL be (floor((HEIGHT-WINDOW)/STRIDE)+1)*(floor((WIDTH-WINDOW)/STRIDE)+1).
REQ-032 Contents left from a previous frame SHALL never appear in any emitted window of the new frame.
REQ-033 Simultaneous output transfer and qualifying input transfer SHALL load the new window with win_valid held at 1, losing no cycle.

Reset
REQ-034 rst=1 SHALL immediately clear to zero: the row and column counters, win_valid, win_last and win_data.
REQ-035 Line-buffer and window-register contents need not be cleared.
REQ-036 rst asserted mid-frame SHALL discard the partial frame; the first input after release is pixel (0,0).

Verification (WIDTH=8, HEIGHT=6, PIXEL_WIDTH=8, CHANNELS=1, WINDOW=3; in_data=R*8+C unless stated)
REQ-037 Scenario, STRIDE=1, win_ready=1, in_valid=1, first pixel has in_sof=1:
- first win_valid one cycle after pixel (2,2), with sample (0,0)=0, (1,1)=9, (2,2)=18;
- 24 windows total;
- win_last only on the window ending at (5,7), with sample (2,2)=47.
REQ-038 Scenario, STRIDE=2, same frame -> exactly 6 windows, ending at (2,2), (2,4), (2,6), (4,2), (4,4), (4,6); win_last on (4,6).
REQ-039 Scenario, STRIDE=1, win_ready=0 for 10 cycles after the first window:
- in_ready=0 throughout;
- win_data stays 0/9/18;
- after release, the 24-window sequence is unchanged and has no gaps.
REQ-040 Scenario, in_sof=1 reasserted at pixel (3,4) of frame 1 -> frame 2 restarts at (0,0); the first frame-2 window follows its pixel (2,2) and contains only frame-2 values.
REQ-041 Scenario, rst pulsed for 1 cycle after pixel (4,0), then a fresh frame -> all outputs are 0 during reset; the fresh frame yields 24 windows identical to REQ-037.
REQ-042 Scenario, CHANNELS=3, STRIDE=1, channel ch value = (R*8+C)+64*ch -> at pixel (2,2), sample (2,2) reads 18, 82, 146 for ch 0, 1, 2.
